// File: rtl/fsmc_pkg.sv
// Shared types and defaults for the FSMC slave front-end.
// Holds the access FSM encoding, bus width defaults and the error counter width.
package fsmc_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 2;
    localparam int ERR_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_ACT  = 2'd1,
        ST_RD_ACT  = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_e;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fsmc_sync.sv
// Single-bit synchroniser for an idle-high asynchronous strobe; exposes the last two stages.
// Latency STAGES-1 cycles to s_cur; no backpressure (free-running).
module fsmc_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s_prev,
    output logic s_cur
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '1;
        end else begin
            chain_q <= chain_d;
        end
    end

    // s_prev is the older sample, so s_prev=1/s_cur=0 marks a falling edge.
    assign s_cur  = chain_q[STAGES-2];
    assign s_prev = chain_q[STAGES-1];

endmodule

// File: rtl/fsmc_frontend.sv
// FSMC async slave front-end: synchronises strobes, emits one-cycle wr_stb/rd_stb to the core.
// Latency ~SYNC_STAGES cycles from strobe edge; no backpressure, core must answer rd_stb next cycle.
// FSMC_GLITCH_FILTER_EN: falling strobe edges must stay low 2 more cycles before acceptance.
module fsmc_frontend
    import fsmc_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              noe,
    input  logic              nwe,
    input  logic              nce2,
    input  logic [AW-1:0]     addr,
    inout  wire  [DW-1:0]     data,
    output logic              wr_stb,
    output logic [AW-1:0]     wr_addr,
    output logic [DW-1:0]     wr_data,
    output logic              rd_stb,
    output logic [AW-1:0]     rd_addr,
    input  logic [DW-1:0]     rd_data,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int STW = $clog2(SYNC_STAGES + 1);

    logic noe_prev, noe_cur, nwe_prev, nwe_cur, nce_prev, nce_cur;

    fsmc_sync #(.STAGES(SYNC_STAGES)) u_sync_noe (
        .clk(clk), .rst_n(rst_n), .din(noe),  .s_prev(noe_prev), .s_cur(noe_cur));
    fsmc_sync #(.STAGES(SYNC_STAGES)) u_sync_nwe (
        .clk(clk), .rst_n(rst_n), .din(nwe),  .s_prev(nwe_prev), .s_cur(nwe_cur));
    fsmc_sync #(.STAGES(SYNC_STAGES)) u_sync_nce (
        .clk(clk), .rst_n(rst_n), .din(nce2), .s_prev(nce_prev), .s_cur(nce_cur));

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DW-1:0]     data_q, wr_data_q, wr_data_d, hold_q, hold_d;
    logic              wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d, rd_stb_dly_q;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [STW-1:0]    settle_q, settle_d;
    logic              armed_q, armed_d;
    logic              settled, err_inc;
    logic              noe_fall, nwe_fall, noe_acc, nwe_acc;
    logic              noe_rise, nwe_rise, nce_rise;

    assign noe_rise = ~noe_prev & noe_cur;
    assign nwe_rise = ~nwe_prev & nwe_cur;
    assign nce_rise = ~nce_prev & nce_cur;

`ifdef FSMC_GLITCH_FILTER_EN
    logic [1:0] noe_low_q, noe_low_d, nwe_low_q, nwe_low_d;

    always_comb begin
        noe_low_d = noe_cur ? 2'd0 : ((noe_low_q == 2'd3) ? 2'd3 : noe_low_q + 2'd1);
        nwe_low_d = nwe_cur ? 2'd0 : ((nwe_low_q == 2'd3) ? 2'd3 : nwe_low_q + 2'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noe_low_q <= 2'd0;
            nwe_low_q <= 2'd0;
        end else begin
            noe_low_q <= noe_low_d;
            nwe_low_q <= nwe_low_d;
        end
    end

    // Third consecutive low cycle of the synced strobe.
    assign noe_fall = ~noe_cur & (noe_low_q == 2'd2);
    assign nwe_fall = ~nwe_cur & (nwe_low_q == 2'd2);
`else
    assign noe_fall = noe_prev & ~noe_cur;
    assign nwe_fall = nwe_prev & ~nwe_cur;
`endif

    // Chains reset to idle-high, so a strobe still low at reset release looks like a
    // falling edge; edges count only once both strobes were seen high after settling.
    assign settled = (settle_q == STW'(SYNC_STAGES));
    assign noe_acc = noe_fall & armed_q;
    assign nwe_acc = nwe_fall & armed_q;

    always_comb begin
        state_d   = state_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        hold_d    = hold_q;
        tmo_d     = '0;
        err_inc   = 1'b0;
        settle_d  = settled ? settle_q : settle_q + STW'(1);
        armed_d   = armed_q | (settled & noe_cur & nwe_cur);

        if (state_q == ST_RD_WAIT && rd_stb_dly_q) begin
            hold_d = rd_data;
        end

        if (state_q == ST_IDLE) begin
            if ((noe_acc | nwe_acc) & ~noe_cur & ~nwe_cur) begin
                err_inc = 1'b1;
            end else if (nwe_acc & ~nce_cur) begin
                state_d = ST_WR_ACT;
            end else if (noe_acc & ~nce_cur) begin
                state_d   = ST_RD_ACT;
                rd_stb_d  = 1'b1;
                rd_addr_d = addr_q;
            end
        end else begin
            tmo_d = tmo_q + TW'(1);
            if (nce_rise || tmo_q == TW'(TIMEOUT)) begin
                state_d = ST_IDLE;
                err_inc = 1'b1;
            end else begin
                case (state_q)
                    ST_WR_ACT: begin
                        if (nwe_rise) begin
                            state_d   = ST_IDLE;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = data_q;
                        end
                    end
                    ST_RD_ACT:  state_d = ST_RD_WAIT;
                    ST_RD_WAIT: if (noe_rise) state_d = ST_IDLE;
                    default:    state_d = ST_IDLE;
                endcase
            end
        end

        err_d = err_inc ? sat_inc(err_q) : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_addr_q    <= '0;
            hold_q       <= '0;
            wr_stb_q     <= 1'b0;
            rd_stb_q     <= 1'b0;
            rd_stb_dly_q <= 1'b0;
            tmo_q        <= '0;
            err_q        <= '0;
            settle_q     <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr;
            data_q       <= data;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_addr_q    <= rd_addr_d;
            hold_q       <= hold_d;
            wr_stb_q     <= wr_stb_d;
            rd_stb_q     <= rd_stb_d;
            rd_stb_dly_q <= rd_stb_q;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            settle_q     <= settle_d;
            armed_q      <= armed_d;
        end
    end

    // Bus turnaround follows the raw pins so the host sees data without sync delay.
    assign data    = (!noe && !nce2) ? hold_q : {DW{1'bz}};
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_stb  = rd_stb_q;
    assign rd_addr = rd_addr_q;
    assign err_cnt = err_q;

endmodule
